sae_stream_ctrl: RTL and testbench



---
 rtl/sae_stream_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_sae_stream_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sae_stream_ctrl.sv
// Front-end sequencer for the sae core. Buffers a byte stream in a small FIFO and feeds the core one byte at a time.
// Each result returns downstream with its error flags. A sae response that never arrives is aborted after TIMEOUT cycles.
module sae_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [7:0]       cfg_key,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic [3:0]       m_err,
  output logic             m_last,
  input  logic             m_ready,
  output logic [1:0]       sae_mode,
  output logic [7:0]       sae_data_input,
  output logic [7:0]       sae_key_input,
  output logic             sae_inputs_valid,
  input  logic [7:0]       sae_data_output,
  input  logic             sae_output_ready,
  input  logic             sae_err_invalid_ptxt_char,
  input  logic             sae_err_invalid_seckey,
  input  logic             sae_err_invalid_ctxt_char,
  output logic             busy,
  output logic [CNT_W-1:0] byte_count
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_EMIT
  } state_e;

  state_e state_q, state_d;

  logic [8:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q;
  logic              fifo_empty, push, pop;
  logic [8:0]        fifo_head;

  logic [1:0]       mode_q, mode_d;
  logic [7:0]       key_q, key_d;
  logic             keygen_q, keygen_d;
  logic             last_q, last_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       sae_mode_q, sae_mode_d;
  logic [7:0]       sae_data_q, sae_data_d;
  logic [7:0]       sae_key_q, sae_key_d;
  logic [7:0]       m_data_q, m_data_d;
  logic [3:0]       m_err_q, m_err_d;
  logic             m_last_q, m_last_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign s_ready    = (fifo_cnt_q < FIFO_FULL);
  assign push       = s_valid & s_ready;
  // The keygen operation synthesises its 0x00 input, so it must not consume a FIFO entry.
  assign pop        = (state_q == S_ISSUE) & ~keygen_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= 2'b00;
      key_q      <= 8'h00;
      keygen_q   <= 1'b0;
      last_q     <= 1'b0;
      timer_q    <= '0;
      sae_mode_q <= 2'b00;
      sae_data_q <= 8'h00;
      sae_key_q  <= 8'h00;
      m_data_q   <= 8'h00;
      m_err_q    <= 4'h0;
      m_last_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      key_q      <= key_d;
      keygen_q   <= keygen_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      sae_mode_q <= sae_mode_d;
      sae_data_q <= sae_data_d;
      sae_key_q  <= sae_key_d;
      m_data_q   <= m_data_d;
      m_err_q    <= m_err_d;
      m_last_q   <= m_last_d;
      count_q    <= count_d;
    end
  end

  // The sae-facing operands are registered when ISSUE is entered, so they stay put through WAIT.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = key_q;
    keygen_d   = keygen_q;
    last_d     = last_q;
    timer_d    = timer_q;
    sae_mode_d = sae_mode_q;
    sae_data_d = sae_data_q;
    sae_key_d  = sae_key_q;
    m_data_d   = m_data_q;
    m_err_d    = m_err_q;
    m_last_d   = m_last_q;
    count_d    = count_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_load) begin
          mode_d = cfg_mode;
          key_d  = cfg_key;
          if (cfg_mode == 2'b01) begin
            state_d    = S_ISSUE;
            keygen_d   = 1'b1;
            last_d     = 1'b1;
            sae_mode_d = cfg_mode;
            sae_key_d  = cfg_key;
            sae_data_d = 8'h00;
          end
        end else if (mode_q[1] && !fifo_empty) begin
          state_d    = S_ISSUE;
          keygen_d   = 1'b0;
          last_d     = fifo_head[8];
          sae_mode_d = mode_q;
          sae_key_d  = key_q;
          sae_data_d = fifo_head[7:0];
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (sae_output_ready) begin
          m_data_d = sae_data_output;
          m_err_d  = {1'b0, sae_err_invalid_ctxt_char, sae_err_invalid_seckey,
                      sae_err_invalid_ptxt_char};
          m_last_d = last_q;
          state_d  = S_EMIT;
        end else if (timer_q == TMR_LAST) begin
          m_data_d = 8'h00;
          m_err_d  = 4'b1000;
          m_last_d = last_q;
          state_d  = S_EMIT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_EMIT: begin
        if (m_ready) begin
          count_d = count_q + CNT_W'(1);
          if (mode_q[1] && !fifo_empty) begin
            state_d    = S_ISSUE;
            keygen_d   = 1'b0;
            last_d     = fifo_head[8];
            sae_mode_d = mode_q;
            sae_key_d  = key_q;
            sae_data_d = fifo_head[7:0];
          end else begin
            state_d    = S_IDLE;
            sae_mode_d = 2'b00;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign sae_inputs_valid = (state_q == S_ISSUE);
  assign sae_mode         = sae_mode_q;
  assign sae_data_input   = sae_data_q;
  assign sae_key_input    = sae_key_q;
  assign m_valid          = (state_q == S_EMIT);
  assign m_data           = m_data_q;
  assign m_err            = m_err_q;
  assign m_last           = m_last_q;
  assign busy             = (state_q != S_IDLE);
  assign byte_count       = count_q;

endmodule

// File: tb/tb_sae_stream_ctrl.sv
// Scoreboard bench for sae_stream_ctrl with a behavioural sae stub (xor cipher, one-cycle response).
// Expected results come from the cipher rules applied to each accepted byte.
module tb_sae_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_load;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_key;
  logic        s_valid, s_last, s_ready;
  logic [7:0]  s_data;
  logic        m_valid, m_last, m_ready;
  logic [7:0]  m_data;
  logic [3:0]  m_err;
  logic [1:0]  sae_mode;
  logic [7:0]  sae_data_input, sae_key_input, sae_data_output;
  logic        sae_inputs_valid, sae_output_ready;
  logic        sae_err_invalid_ptxt_char, sae_err_invalid_seckey, sae_err_invalid_ctxt_char;
  logic        busy;
  logic [15:0] byte_count;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] err;
    logic       last;
  } expT;

  expT  expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   deliveredCount = 0;
  logic [1:0] modelMode = 2'b00;
  logic [7:0] modelKey = 8'h00;
  bit   stubDead = 1'b0;
  bit   randReady = 1'b0;

  always #5 clk = ~clk;

  sae_stream_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_err(m_err), .m_last(m_last), .m_ready(m_ready),
    .sae_mode(sae_mode), .sae_data_input(sae_data_input), .sae_key_input(sae_key_input),
    .sae_inputs_valid(sae_inputs_valid), .sae_data_output(sae_data_output),
    .sae_output_ready(sae_output_ready),
    .sae_err_invalid_ptxt_char(sae_err_invalid_ptxt_char),
    .sae_err_invalid_seckey(sae_err_invalid_seckey),
    .sae_err_invalid_ctxt_char(sae_err_invalid_ctxt_char),
    .busy(busy), .byte_count(byte_count)
  );

  // sae stand-in: answers one cycle after inputs_valid unless stubDead silences it.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sae_output_ready          <= 1'b0;
      sae_data_output           <= 8'h00;
      sae_err_invalid_ptxt_char <= 1'b0;
    end else begin
      sae_output_ready          <= sae_inputs_valid & ~stubDead;
      sae_data_output           <= sae_data_input ^ sae_key_input;
      sae_err_invalid_ptxt_char <= sae_inputs_valid && (sae_mode == 2'b10) && (sae_data_input > 8'h7F);
    end
  end
  assign sae_err_invalid_seckey    = 1'b0;
  assign sae_err_invalid_ctxt_char = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic expT predict(input logic [7:0] d, input logic l, input bit tmo);
    expT e;
    if (tmo) begin
      e.data = 8'h00;
      e.err  = 4'b1000;
    end else begin
      e.data = d ^ modelKey;
      e.err  = (modelMode == 2'b10 && d >= 8'h80) ? 4'b0001 : 4'b0000;
    end
    e.last = l;
    return e;
  endfunction

  // Monitor: every completed output handshake is compared with the oldest prediction.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && m_valid && m_ready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got data 0x%0h with no prediction pending", m_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("m_data", m_data, e.data);
          checkOutput("m_err", m_err, e.err);
          checkOutput("m_last", m_last, e.last);
          deliveredCount++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (randReady) m_ready = 1'($urandom_range(0, 1));
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input bit tmo);
    bit acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int i = 0; i < 300 && !acc; i++) begin
      if (s_ready) begin
        @(posedge clk);
        expQ.push_back(predict(d, l, tmo));
        acc = 1'b1;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    checkOutput("push_accept", acc, 1);
  endtask

  task automatic loadCfg(input logic [1:0] mode, input logic [7:0] key, input bit accepted);
    cfg_load = 1'b1;
    cfg_mode = mode;
    cfg_key  = key;
    @(posedge clk);
    if (accepted) begin
      modelMode = mode;
      modelKey  = key;
      if (mode == 2'b01) expQ.push_back('{data: key, err: 4'b0000, last: 1'b1});
    end
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic waitDrain();
    bit done = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(negedge clk);
      if (expQ.size() == 0 && !busy && !m_valid) done = 1'b1;
    end
    checkOutput("drain", done, 1);
  endtask

  task automatic cyclesToValid(output int n, input int limit);
    n = 0;
    while (!m_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cfg_load = 1'b0; cfg_mode = 2'b00; cfg_key = 8'h00;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_sae_valid", sae_inputs_valid, 0);
    checkOutput("rst_sae_mode", sae_mode, 0);
    checkOutput("rst_outputs", {m_data, m_err, m_last, sae_data_input, sae_key_input}, 0);
    checkOutput("rst_byte_count", byte_count, 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] keygen");
    m_ready = 1'b1;
    loadCfg(2'b01, 8'h2A, 1'b1);
    waitDrain();
    checkOutput("keygen_busy", busy, 0);

    $display("[TB] encrypt stream");
    loadCfg(2'b10, 8'h2A, 1'b1);
    applyStimulus(8'h41, 1'b0, 1'b0);
    cyclesToValid(n, 20);
    checkOutput("first_latency", n, 3);
    applyStimulus(8'h42, 1'b0, 1'b0);
    applyStimulus(8'h43, 1'b1, 1'b0);
    waitDrain();
    checkOutput("byte_count_enc", byte_count, 16'(deliveredCount));
    checkOutput("byte_count_enc_abs", byte_count, 4);

    $display("[TB] backpressure");
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h10 + i), 1'b0, 1'b0);
    checkOutput("s_ready_full", s_ready, 0);
    repeat (3) @(negedge clk);
    checkOutput("s_ready_full_hold", s_ready, 0);
    checkOutput("m_valid_held", m_valid, 1);
    m_ready = 1'b1;
    applyStimulus(8'h15, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] error passthrough and ignored load");
    m_ready = 1'b0;
    applyStimulus(8'h90, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    loadCfg(2'b11, 8'h55, 1'b0);
    m_ready = 1'b1;
    applyStimulus(8'h21, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] timeout");
    m_ready = 1'b0;
    stubDead = 1'b1;
    applyStimulus(8'h33, 1'b0, 1'b1);
    cyclesToValid(n, 40);
    checkOutput("timeout_latency", n, 10);
    stubDead = 1'b0;
    applyStimulus(8'h44, 1'b1, 1'b0);
    m_ready = 1'b1;
    waitDrain();

    $display("[TB] random streams");
    for (int r = 0; r < 3; r++) begin
      loadCfg((r == 1) ? 2'b11 : 2'b10, 8'($urandom), 1'b1);
      randReady = 1'b1;
      for (int i = 0; i < 30; i++) begin
        applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1'b0);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      end
      waitDrain();
      randReady = 1'b0;
      m_ready = 1'b1;
    end
    checkOutput("byte_count_rand", byte_count, 16'(deliveredCount));

    $display("[TB] reset mid-wait");
    stubDead = 1'b1;
    loadCfg(2'b10, 8'h3C, 1'b1);
    applyStimulus(8'h01, 1'b0, 1'b1);
    applyStimulus(8'h02, 1'b0, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_m_valid", m_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_sae", {sae_inputs_valid, sae_mode, sae_data_input, sae_key_input}, 0);
    checkOutput("mid_rst_outputs", {m_data, m_err, m_last}, 0);
    checkOutput("mid_rst_count", byte_count, 0);
    checkOutput("mid_rst_s_ready", s_ready, 1);
    expQ.delete();
    deliveredCount = 0;
    modelMode = 2'b00;
    modelKey = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    stubDead = 1'b0;
    loadCfg(2'b10, 8'h0F, 1'b1);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_valid || busy) n++;
    end
    checkOutput("post_rst_quiet", n, 0);
    applyStimulus(8'h70, 1'b1, 1'b0);
    waitDrain();
    checkOutput("post_rst_count", byte_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
